// File: rtl/if_stage_p.sv
// Fetch stage: PC issues word reads to a 1-cycle ROM; returns land in a Q_DEPTH queue that feeds decode over valid/ready.
// Head is visible the cycle after the push; back-pressure fills the queue, then issue stops and the PC holds.
module if_stage_p #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              ROM_AW   = 6,
    parameter int              Q_DEPTH  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_plus4
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(Q_DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [INST_W-1:0] q_inst_q [Q_DEPTH];
    logic [PC_W-1:0]   q_pc_q   [Q_DEPTH];
    logic [PC_W-1:0]   q_pc4_q  [Q_DEPTH];
    logic              pop, push, issue;
    logic [CNT_W:0]    occupancy;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid    = (count_q != '0);
    assign out_inst     = q_inst_q[rd_ptr_q];
    assign out_pc       = q_pc_q[rd_ptr_q];
    assign out_pc_plus4 = q_pc4_q[rd_ptr_q];

    assign pop  = out_valid && out_ready;
    // A returning word in a redirect cycle belongs to the old path and is dropped.
    assign push = inflight_q && !redirect_valid;

    // Queued plus in-flight words after this cycle's pop must leave room for one more.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign issue     = !rst && !redirect_valid && (occupancy < DEPTH);

    assign rom_en   = issue;
    assign rom_addr = pc_q[ROM_AW+1:2];

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[PC_W-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + PC_W'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
                q_pc4_q[i]  <= '0;
            end
        end else if (push) begin
            q_inst_q[wr_ptr_q] <= rom_data;
            q_pc_q[wr_ptr_q]   <= inflight_pc_q;
            q_pc4_q[wr_ptr_q]  <= inflight_pc_q + PC_W'(4);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CNT_W'(Q_DEPTH)));

endmodule

// File: tb/tb_if_stage_p.sv
module tb_if_stage_p;
    localparam int Q_DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic [31:0] out_inst, out_pc, out_pc_plus4;

    logic        rst_w;
    logic        rom_en_w;
    logic [5:0]  rom_addr_w;
    logic [31:0] rom_data_w;
    logic        out_valid_w;
    logic [31:0] out_inst_w, out_pc_w, out_pc_plus4_w;

    int checks = 0;
    int errors = 0;

    if_stage_p #(.PC_W(32), .INST_W(32), .ROM_AW(6), .Q_DEPTH(Q_DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
    );

    if_stage_p #(.PC_W(32), .INST_W(32), .ROM_AW(6), .Q_DEPTH(Q_DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .rom_en(rom_en_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .out_valid(out_valid_w), .out_ready(1'b1), .out_inst(out_inst_w),
        .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w)
    );

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return 32'h1000_0000 + {26'd0, a};
    endfunction

    always @(posedge clk) if (rom_en)   rom_data   <= rom_word(rom_addr);
    always @(posedge clk) if (rom_en_w) rom_data_w <= rom_word(rom_addr_w);

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: every issued fetch is an entry {pc, cycle it becomes visible}; FIFO order, flushed on redirect.
    typedef struct { logic [31:0] pc; int avail; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    int          cyc = 0;
    logic [31:0] dut_acc[$];

    always @(negedge clk) begin
        bit ev, ep, ei;
        if (rst) begin
            chk("m_rst_valid", out_valid, 0);
            chk("m_rst_rom_en", rom_en, 0);
            mq.delete();
            m_pc = 32'h0;
        end else begin
            ev = (mq.size() > 0) && (mq[0].avail <= cyc);
            chk("m_valid", out_valid, ev);
            if (ev) begin
                chk("m_pc", out_pc, mq[0].pc);
                chk("m_inst", out_inst, 32'h1000_0000 + ((mq[0].pc >> 2) & 32'h3F));
                chk("m_pc4", out_pc_plus4, mq[0].pc + 32'd4);
            end
            ep = ev && out_ready;
            ei = !redirect_valid && ((mq.size() - int'(ep)) < Q_DEPTH);
            chk("m_rom_en", rom_en, ei);
            if (ei) chk("m_rom_addr", rom_addr, m_pc[7:2]);
            if (out_valid && out_ready) dut_acc.push_back(out_pc);
            if (ep) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & ~32'h3;
            end else if (ei) begin
                mq.push_back('{m_pc, cyc + 2});
                m_pc += 32'd4;
            end
        end
        cyc++;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        int n = 0;
        while (!out_valid && n < maxc) begin
            adv();
            @(negedge clk);
            n++;
        end
        chk(nm, out_valid, 1);
    endtask

    initial begin
        int n44, n104;
        rst = 1'b1; rst_w = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_pc4", out_pc_plus4, 0);
        chk("rst_w_pc", out_pc_w, 0);

        // Cycle 0 after release: first issue.
        adv(); rst = 1'b0;
        @(negedge clk); chk("c0_rom_en", rom_en, 1); chk("c0_addr", rom_addr, 0);
        adv(); @(negedge clk); chk("c1_valid", out_valid, 0); chk("c1_addr", rom_addr, 1);
        adv(); @(negedge clk);
        chk("c2_valid", out_valid, 1); chk("c2_inst", out_inst, 32'h1000_0000);
        chk("c2_pc", out_pc, 0); chk("c2_pc4", out_pc_plus4, 4);
        adv(); @(negedge clk); chk("c3_pc", out_pc, 4);
        adv(); @(negedge clk); chk("c4_pc", out_pc, 8);

        // Back-pressure: head 12 held, issue stops once two words are owed.
        adv(); out_ready = 1'b0;
        @(negedge clk); chk("c5_pc", out_pc, 12);
        adv(); @(negedge clk); chk("c6_rom_en", rom_en, 0); chk("c6_pc", out_pc, 12);
        adv(); @(negedge clk); chk("c7_rom_en", rom_en, 0); chk("c7_valid", out_valid, 1);
        adv(); out_ready = 1'b1;
        @(negedge clk); chk("c8_pc", out_pc, 12); chk("c8_addr", rom_addr, 5);
        adv(); @(negedge clk); chk("c9_pc", out_pc, 16);
        adv(); @(negedge clk); chk("c10_pc", out_pc, 20);

        // Redirect to 0x43 with a full queue.
        adv(); out_ready = 1'b0;
        @(negedge clk); chk("c11_pc", out_pc, 24);
        adv(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        @(negedge clk); chk("c12_rom_en", rom_en, 0); chk("c12_valid", out_valid, 1);
        adv(); redirect_valid = 1'b0;
        @(negedge clk); chk("c13_valid", out_valid, 0); chk("c13_rom_en", rom_en, 1);
        chk("c13_addr", rom_addr, 6'h10);
        adv(); out_ready = 1'b1;
        @(negedge clk);
        wait_valid("rd1_seen", 4);
        chk("rd1_pc", out_pc, 32'h40); chk("rd1_inst", out_inst, 32'h1000_0010);

        // Redirect coinciding with a pop, then a second redirect overriding it.
        adv(); @(negedge clk); chk("pre_rd2_pc", out_pc, 32'h44);
        adv(); redirect_valid = 1'b1; redirect_pc = 32'h104;
        @(negedge clk);
        adv(); redirect_pc = 32'h208;
        @(negedge clk); chk("rd3_valid", out_valid, 0);
        adv(); redirect_valid = 1'b0;
        @(negedge clk); chk("rd3_addr", rom_addr, 2);
        wait_valid("rd3_seen", 4);
        chk("rd3_pc", out_pc, 32'h208); chk("rd3_inst", out_inst, 32'h1000_0002);
        n44 = 0; n104 = 0;
        foreach (dut_acc[i]) begin
            if (dut_acc[i] == 32'h44)  n44++;
            if (dut_acc[i] == 32'h104) n104++;
        end
        chk("acc_0x44_once", n44, 1);
        chk("acc_0x104_none", n104, 0);

        // Asynchronous reset between edges.
        adv(); @(negedge clk); chk("pre_arst_valid", out_valid, 1); chk("pre_arst_en", rom_en, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0); chk("arst_rom_en", rom_en, 0);
        chk("arst_pc", out_pc, 0); chk("arst_pc4", out_pc_plus4, 0);
        adv(); adv(); rst = 1'b0;
        @(negedge clk); chk("post_arst_en", rom_en, 1); chk("post_arst_addr", rom_addr, 0);
        adv(); @(negedge clk); chk("post_arst_v0", out_valid, 0);
        adv(); @(negedge clk);
        chk("post_arst_valid", out_valid, 1); chk("post_arst_pc", out_pc, 0);
        chk("post_arst_inst", out_inst, 32'h1000_0000);

        // Wrap of PC and ROM address from RESET_PC = 0xFFFF_FFFC.
        adv(); rst_w = 1'b0;
        @(negedge clk); chk("w0_en", rom_en_w, 1); chk("w0_addr", rom_addr_w, 6'h3F);
        adv(); @(negedge clk); chk("w1_addr", rom_addr_w, 6'h00); chk("w1_valid", out_valid_w, 0);
        adv(); @(negedge clk);
        chk("w2_valid", out_valid_w, 1); chk("w2_pc", out_pc_w, 32'hFFFF_FFFC);
        chk("w2_pc4", out_pc_plus4_w, 0); chk("w2_inst", out_inst_w, 32'h1000_003F);
        adv(); @(negedge clk);
        chk("w3_pc", out_pc_w, 0); chk("w3_pc4", out_pc_plus4_w, 4);
        chk("w3_inst", out_inst_w, 32'h1000_0000);

        adv(); @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
